mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding, default parameters and address-check helper for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_DEF  = 2;
    localparam int WORDS_DEF = 256;

    localparam logic [1:0] ALIGN_OK = 2'b00;

    // A request is rejected when misaligned or when its word index falls beyond the array.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] words);
        return (addr[1:0] != ALIGN_OK) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/mem_array.sv
// WORDS x 32 storage: synchronous write, combinational read through a single address.
module mem_array
    import mem_pkg::*;
#(
    parameter int WORDS = WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] storage [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            storage[addr] <= wdata;
        end
    end

    assign rdata = storage[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states and a write monitor port.
// state   | meaning
// ST_IDLE | ready; samples req and captures the transaction
// ST_WAIT | counting wait states down to terminal count 0
// ST_RESP | one-cycle completion: ack (+err / rdata / monitor)
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int WAIT  = WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mon_valid,
    output logic [31:0] mon_addr,
    output logic [31:0] mon_data
);

    localparam int         AW       = $clog2(WORDS);
    localparam logic [2:0] CNT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    state_t      state;
    logic [2:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_bad;
    logic        to_resp;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // With WAIT=0 the commit edge is also the capture edge, so the live inputs are used.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        to_resp   = 1'b0;
        if (state == ST_IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            to_resp   = req && (WAIT == 0);
        end else if (state == ST_WAIT) begin
            to_resp = (cnt == 3'd0);
        end
    end

    assign cur_bad = addr_bad(cur_addr, 32'(WORDS));
    assign mem_we  = to_resp && !reset && cur_we && !cur_bad;
    assign busy    = (state != ST_IDLE);

    mem_array #(.WORDS(WORDS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            mon_valid <= 1'b0;
            mon_addr  <= 32'd0;
            mon_data  <= 32'd0;
        end else begin
            ack       <= 1'b0;
            err       <= 1'b0;
            mon_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (to_resp) begin
                ack <= 1'b1;
                err <= cur_bad;
                if (!cur_bad) begin
                    if (cur_we) begin
                        mon_valid <= 1'b1;
                        mon_addr  <= cur_addr;
                        mon_data  <= cur_wdata;
                    end else begin
                        rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic against a cycle-schedule model.
module tb_mem_responder;

    localparam int WORDS = 256;
    localparam int WAITC = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        req_z = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        busy, ack, err, mon_valid;
    logic [31:0] rdata, mon_addr, mon_data;
    logic        busy_z, ack_z, err_z, mv_z;
    logic [31:0] rdata_z, ma_z, md_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORDS(WORDS), .WAIT(WAITC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .mon_valid(mon_valid), .mon_addr(mon_addr), .mon_data(mon_data)
    );

    mem_responder #(.WORDS(WORDS), .WAIT(0)) dut_z (
        .clk(clk), .reset(reset), .req(req_z), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_z), .ack(ack_z), .err(err_z), .rdata(rdata_z),
        .mon_valid(mv_z), .mon_addr(ma_z), .mon_data(md_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction schedule in cycle numbers plus a plain word array.
    logic [31:0] mm [WORDS];
    bit          mk [WORDS];
    bit          started = 0, pending = 0;
    bit          e_busy, e_ack, e_err, e_mv, e_rk;
    int          cyc = 0, p_start = 0, next_free = 0;
    bit          p_we;
    logic [31:0] p_addr, p_wdata, e_rdata, e_ma, e_md;
    int          ack_count = 0, mv_count = 0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * WORDS));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            e_ack = 0;
            e_err = 0;
            e_mv  = 0;
            if (reset) begin
                started   = 1;
                pending   = 0;
                next_free = cyc + 1;
                e_rdata   = 32'd0;
                e_rk      = 1;
                e_busy    = 0;
            end else begin
                if (!pending && cyc >= next_free && req) begin
                    pending = 1;
                    p_start = cyc;
                    p_we    = we;
                    p_addr  = addr;
                    p_wdata = wdata;
                end
                if (pending && cyc == p_start + WAITC) begin
                    pending   = 0;
                    e_ack     = 1;
                    next_free = cyc + 2;
                    if (bad_addr(p_addr)) begin
                        e_err = 1;
                    end else if (p_we) begin
                        mm[int'(p_addr >> 2)] = p_wdata;
                        mk[int'(p_addr >> 2)] = 1;
                        e_mv = 1;
                        e_ma = p_addr;
                        e_md = p_wdata;
                    end else begin
                        e_rdata = mm[int'(p_addr >> 2)];
                        e_rk    = mk[int'(p_addr >> 2)];
                    end
                end
                e_busy = pending || e_ack;
            end
            #1;
            if (started) begin
                chk1("busy", busy, e_busy);
                chk1("ack", ack, e_ack);
                chk1("err", err, e_err);
                chk1("mon_valid", mon_valid, e_mv);
                if (e_rk) chk("rdata", rdata, e_rdata);
                if (e_mv) begin
                    chk("mon_addr", mon_addr, e_ma);
                    chk("mon_data", mon_data, e_md);
                end
                if (ack) ack_count++;
                if (mon_valid) mv_count++;
            end
        end
    end

    task automatic txn(input bit z, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output bit e, output logic [31:0] rd,
                       output bit mv, output logic [31:0] ma, output logic [31:0] md);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
        if (z) req_z = 1'b1;
        else   req   = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        req_z = 1'b0;
        lat = 0; e = 0; rd = 32'd0; mv = 0; ma = 32'd0; md = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            if (z ? ack_z : ack) begin
                lat = i;
                e   = z ? err_z : err;
                rd  = z ? rdata_z : rdata;
                mv  = z ? mv_z : mon_valid;
                ma  = z ? ma_z : mon_addr;
                md  = z ? md_z : mon_data;
                break;
            end
            @(negedge clk);
        end
        chk1("ack_seen", z ? ack_z : ack, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, k1, k2, a0, m0;
        bit          e, mv;
        logic [31:0] rd, ma, md, ma1, md1, ma2, md2, wa, wd;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack", ack, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Basic write then read with two wait states
        txn(0, 1, 32'h2E0, 32'h400, lat, e, rd, mv, ma, md);
        chk("wr_latency", 32'(lat), 32'd3);
        chk1("wr_err", e, 1'b0);
        chk1("wr_mon_valid", mv, 1'b1);
        chk("wr_mon_addr", ma, 32'h2E0);
        chk("wr_mon_data", md, 32'h400);
        txn(0, 0, 32'h2E0, 32'h0, lat, e, rd, mv, ma, md);
        chk("rd_latency", 32'(lat), 32'd3);
        chk1("rd_err", e, 1'b0);
        chk("rd_data", rd, 32'h400);

        // Misaligned write is rejected and leaves storage alone
        txn(0, 1, 32'h2E2, 32'h5555_AAAA, lat, e, rd, mv, ma, md);
        chk1("mis_err", e, 1'b1);
        chk1("mis_mon_valid", mv, 1'b0);
        txn(0, 0, 32'h2E0, 32'h0, lat, e, rd, mv, ma, md);
        chk("mis_readback", rd, 32'h400);

        // Out-of-range read keeps rdata
        txn(0, 0, 32'h400, 32'h0, lat, e, rd, mv, ma, md);
        chk1("oor_err", e, 1'b1);
        chk("oor_rdata_hold", rd, 32'h400);

        // req held high; address changes during WAIT must not affect the current transaction
        @(negedge clk);
        we = 1'b1; addr = 32'h10; wdata = 32'hA1A1_A1A1; req = 1'b1;
        @(negedge clk);
        addr = 32'h14; wdata = 32'hB2B2_B2B2;
        k1 = 0; k2 = 0; ma1 = 0; md1 = 0; ma2 = 0; md2 = 0;
        for (int i = 1; i <= 30 && k2 == 0; i++) begin
            if (ack) begin
                if (k1 == 0) begin
                    k1 = i; ma1 = mon_addr; md1 = mon_data;
                end else begin
                    k2 = i; ma2 = mon_addr; md2 = mon_data;
                end
            end
            @(negedge clk);
        end
        req = 1'b0;
        chk("held_first_lat", 32'(k1), 32'd3);
        chk("held_first_addr", ma1, 32'h10);
        chk("held_first_data", md1, 32'hA1A1_A1A1);
        chk("held_second_lat", 32'(k2), 32'd7);
        chk("held_second_addr", ma2, 32'h14);
        chk("held_second_data", md2, 32'hB2B2_B2B2);

        // Reset during WAIT aborts the write
        txn(0, 1, 32'h20, 32'h1234_5678, lat, e, rd, mv, ma, md);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'hDEAD_BEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        a0 = ack_count; m0 = mv_count;
        @(negedge clk);
        reset = 1'b0;
        chk1("rst2_busy", busy, 1'b0);
        chk1("rst2_ack", ack, 1'b0);
        chk1("rst2_err", err, 1'b0);
        chk("rst2_rdata", rdata, 32'd0);
        chk1("rst2_mon_valid", mon_valid, 1'b0);
        chk("rst2_mon_addr", mon_addr, 32'd0);
        chk("rst2_mon_data", mon_data, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_acks", 32'(ack_count), 32'(a0));
        chk("abort_mon", 32'(mv_count), 32'(m0));
        txn(0, 0, 32'h20, 32'h0, lat, e, rd, mv, ma, md);
        chk("abort_readback", rd, 32'h1234_5678);
        chk1("abort_read_err", e, 1'b0);

        // Zero wait states on the second instance
        txn(1, 1, 32'h2E0, 32'h400, lat, e, rd, mv, ma, md);
        chk("z_wr_latency", 32'(lat), 32'd1);
        chk1("z_wr_mon_valid", mv, 1'b1);
        chk("z_wr_mon_addr", ma, 32'h2E0);
        txn(1, 0, 32'h2E0, 32'h0, lat, e, rd, mv, ma, md);
        chk("z_rd_latency", 32'(lat), 32'd1);
        chk("z_rd_data", rd, 32'h400);
        chk1("z_rd_err", e, 1'b0);
        for (int n = 0; n < 12; n++) begin
            wa = 32'($urandom_range(0, WORDS - 1)) << 2;
            wd = $urandom();
            txn(1, 1, wa, wd, lat, e, rd, mv, ma, md);
            txn(1, 1, wa + 32'($urandom_range(1, 3)), ~wd, lat, e, rd, mv, ma, md);
            chk1("z_mis_err", e, 1'b1);
            txn(1, 0, wa, 32'h0, lat, e, rd, mv, ma, md);
            chk("z_rand_lat", 32'(lat), 32'd1);
            chk("z_rand_data", rd, wd);
        end

        // Randomized traffic on the main instance, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 99) < 55);
            we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
                1:       addr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
                2:       addr = $urandom();
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            wdata = $urandom();
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
